me_sad_collector: RTL and testbench

Collects the per-PE absolute differences (`abs_out`) produced by one row of the motion-estimation PE array. It reduces each row through a registered adder tree and accumulates block SADs candidate by candidate. It tracks the minimum-SAD candidate over a full search window. It sits downstream of the PE array, as the consumer of the array's `abs_out` buses, and reports the best candidate index to the ME controller.

---
 rtl/me_pkg.sv | 26 ++
 rtl/sad_row_adder.sv | 56 +++++
 rtl/me_sad_collector.sv | 157 +++++++++++++++
 tb/tb_me_sad_collector.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SAD path: pixel width,
// derived datapath widths and the collector state encoding.
package me_pkg;

  localparam int unsigned PIXEL = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned pixel, input int unsigned num_pe);
    return pixel + $clog2(num_pe);
  endfunction

  function automatic int unsigned sad_w(input int unsigned pixel, input int unsigned num_pe,
                                        input int unsigned blk_rows);
    return pixel + $clog2(num_pe * blk_rows);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_cand);
    return clog2_min1(num_cand);
  endfunction

endpackage

// File: rtl/sad_row_adder.sv
// Two-cycle row reducer: captures an accepted beat, then registers the sum of
// its NUM_PE lanes. Valid and an opaque tag travel alongside the data.
module sad_row_adder
  import me_pkg::*;
#(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned PIXEL  = me_pkg::PIXEL,
  parameter int unsigned TAG_W  = 1,
  parameter int unsigned ROW_W  = row_w(PIXEL, NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    beat_valid,
  input  logic [NUM_PE*PIXEL-1:0] beat_data,
  input  logic [TAG_W-1:0]        beat_tag,
  output logic                    sum_valid,
  output logic [ROW_W-1:0]        row_sum,
  output logic [TAG_W-1:0]        sum_tag
);

  logic [NUM_PE*PIXEL-1:0] data_q;
  logic                    valid_q;
  logic [TAG_W-1:0]        tag_q;
  logic [ROW_W-1:0]        tree_sum;

  // ROW_W is sized so the full lane sum cannot overflow.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      tree_sum = tree_sum + ROW_W'(data_q[i*PIXEL +: PIXEL]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      sum_valid <= 1'b0;
      row_sum   <= '0;
      sum_tag   <= '0;
    end else begin
      valid_q   <= beat_valid;
      sum_valid <= valid_q;
      if (beat_valid) begin
        data_q <= beat_data;
        tag_q  <= beat_tag;
      end
      if (valid_q) begin
        row_sum <= tree_sum;
        sum_tag <= tag_q;
      end
    end
  end

endmodule

// File: rtl/me_sad_collector.sv
// Reduces PE-array abs-difference rows into per-candidate SADs and tracks the
// minimum-SAD candidate over one search window.
module me_sad_collector
  import me_pkg::*;
#(
  parameter int unsigned PIXEL    = me_pkg::PIXEL,
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned BLK_ROWS = 8,
  parameter int unsigned NUM_CAND = 64,
  parameter int unsigned ROW_W    = row_w(PIXEL, NUM_PE),
  parameter int unsigned SAD_W    = sad_w(PIXEL, NUM_PE, BLK_ROWS),
  parameter int unsigned IDX_W    = idx_w(NUM_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abs_valid,
  input  logic [NUM_PE*PIXEL-1:0] abs_in,
  output logic                    busy,
  output logic                    cand_sad_valid,
  output logic [SAD_W-1:0]        cand_sad,
  output logic [IDX_W-1:0]        cand_idx,
  output logic [SAD_W-1:0]        best_sad,
  output logic [IDX_W-1:0]        best_idx,
  output logic                    done
);

  localparam int unsigned RC_W  = clog2_min1(BLK_ROWS);
  localparam int unsigned TAG_W = IDX_W + 2;

  state_e           state;
  logic [RC_W-1:0]  row_cnt;
  logic [IDX_W-1:0] cand_cnt;
  logic             flush_cnt;

  logic accept;
  logic start_ok;
  logic row_last;
  logic cand_last;

  assign accept    = (state == ACCUM) && abs_valid;
  assign start_ok  = (state == IDLE) && start;
  assign row_last  = (row_cnt == RC_W'(BLK_ROWS - 1));
  assign cand_last = (cand_cnt == IDX_W'(NUM_CAND - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_cnt   <= '0;
      cand_cnt  <= '0;
      flush_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            busy     <= 1'b1;
            row_cnt  <= '0;
            cand_cnt <= '0;
          end
        end
        ACCUM: begin
          if (abs_valid) begin
            if (row_last) begin
              row_cnt <= '0;
              if (cand_last) begin
                state     <= FLUSH;
                flush_cnt <= 1'b0;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Two cycles lets the final row reach the min tracker before done.
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag rides with the row through the adder: {first row, last row, candidate}.
  logic [TAG_W-1:0] beat_tag;
  logic [TAG_W-1:0] sum_tag;
  logic             sum_valid;
  logic [ROW_W-1:0] row_sum;

  assign beat_tag = {row_cnt == '0, row_last, cand_cnt};

  sad_row_adder #(
    .NUM_PE (NUM_PE),
    .PIXEL  (PIXEL),
    .TAG_W  (TAG_W),
    .ROW_W  (ROW_W)
  ) u_row_adder (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (accept),
    .beat_data  (abs_in),
    .beat_tag   (beat_tag),
    .sum_valid  (sum_valid),
    .row_sum    (row_sum),
    .sum_tag    (sum_tag)
  );

  logic             sum_first;
  logic             sum_last;
  logic [IDX_W-1:0] sum_idx;
  logic [SAD_W-1:0] acc_q;
  logic [SAD_W-1:0] acc_next;

  assign {sum_first, sum_last, sum_idx} = sum_tag;
  // First row of a candidate reloads the accumulator, so candidates need no bubble.
  assign acc_next = (sum_first ? '0 : acc_q) + SAD_W'(row_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      cand_sad_valid <= 1'b0;
      cand_sad       <= '0;
      cand_idx       <= '0;
      best_sad       <= '1;
      best_idx       <= '0;
    end else begin
      cand_sad_valid <= 1'b0;
      if (start_ok) begin
        acc_q    <= '0;
        best_sad <= '1;
        best_idx <= '0;
      end else if (sum_valid) begin
        acc_q <= acc_next;
        if (sum_last) begin
          cand_sad_valid <= 1'b1;
          cand_sad       <= acc_next;
          cand_idx       <= sum_idx;
          if (acc_next < best_sad) begin
            best_sad <= acc_next;
            best_idx <= sum_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_me_sad_collector.sv
// Randomized bench for me_sad_collector with a queue-based reference model of
// candidate SADs, running minimum and completion timing.
module tb_me_sad_collector;

  localparam int NP = 8;
  localparam int PX = 8;
  localparam int BR = 8;
  localparam int NC = 4;
  localparam int SW = 14;
  localparam int IW = 2;
  localparam int ALL_ONES = (1 << SW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abs_valid = 1'b0;
  logic [NP*PX-1:0] abs_in = '0;
  logic           busy;
  logic           cand_sad_valid;
  logic [SW-1:0]  cand_sad;
  logic [IW-1:0]  cand_idx;
  logic [SW-1:0]  best_sad;
  logic [IW-1:0]  best_idx;
  logic           done;

  me_sad_collector #(
    .PIXEL    (PX),
    .NUM_PE   (NP),
    .BLK_ROWS (BR),
    .NUM_CAND (NC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abs_valid      (abs_valid),
    .abs_in         (abs_in),
    .busy           (busy),
    .cand_sad_valid (cand_sad_valid),
    .cand_sad       (cand_sad),
    .cand_idx       (cand_idx),
    .best_sad       (best_sad),
    .best_idx       (best_idx),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int sad;
    int idx;
    int bsad;
    int bidx;
  } exp_t;

  exp_t cq[$];
  int   dq[$];

  // Model state for the search in progress.
  int m_acc;
  int m_bsad;
  int m_bidx;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (cq.size() > 0 && cq[0].cyc < cyc) begin
        check("cand_missed", cyc, cq[0].cyc);
        cq.delete(0);
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        check("done_missed", cyc, dq[0]);
        dq.delete(0);
      end
      if (cand_sad_valid) begin
        if (cq.size() == 0) begin
          check("cand_unexpected", 1, 0);
        end else begin
          e = cq[0];
          cq.delete(0);
          check("cand_cycle", cyc, e.cyc);
          check("cand_sad", cand_sad, e.sad);
          check("cand_idx", cand_idx, e.idx);
          check("best_sad_run", best_sad, e.bsad);
          check("best_idx_run", best_idx, e.bidx);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_cycle", cyc, dq[0]);
          dq.delete(0);
        end
      end
    end
  end

  function automatic logic [NP*PX-1:0] make_beat(input int mode, input int c);
    logic [NP*PX-1:0] b;
    int v;
    for (int l = 0; l < NP; l++) begin
      case (mode)
        0:       v = 1;
        1:       v = 255;
        2:       v = (c == 0) ? 5 : (c == 1) ? 3 : (c == 2) ? 7 : 3;
        3:       v = int'($urandom_range(0, 255));
        default: v = int'($urandom_range(0, 2));
      endcase
      b[l*PX +: PX] = PX'(v);
    end
    return b;
  endfunction

  function automatic int beat_sum(input logic [NP*PX-1:0] b);
    int s = 0;
    for (int l = 0; l < NP; l++) s += int'(b[l*PX +: PX]);
    return s;
  endfunction

  // Drives one accepted beat for the next edge and records what it implies.
  task automatic drive_beat(input logic [NP*PX-1:0] b, input int c, input int r);
    exp_t e;
    abs_valid = 1'b1;
    abs_in = b;
    if (r == 0) m_acc = 0;
    m_acc += beat_sum(b);
    if (r == BR - 1) begin
      if (m_acc < m_bsad) begin
        m_bsad = m_acc;
        m_bidx = c;
      end
      e.cyc = cyc + 3;
      e.sad = m_acc;
      e.idx = c;
      e.bsad = m_bsad;
      e.bidx = m_bidx;
      cq.push_back(e);
      if (c == NC - 1) dq.push_back(cyc + 3);
    end
  endtask

  task automatic stray_beats(input int n);
    for (int i = 0; i < n; i++) begin
      abs_valid = 1'b1;
      abs_in = {$urandom, $urandom};
      @(negedge clk);
    end
    abs_valid = 1'b0;
  endtask

  task automatic issue_start();
    abs_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("best_sad_init", best_sad, ALL_ONES);
    check("best_idx_init", best_idx, 0);
    m_bsad = ALL_ONES;
    m_bidx = 0;
  endtask

  task automatic do_search(input int mode, input bit gaps, input bit stray, input bit mid_start,
                           input int lit_sad, input int lit_idx);
    int n;
    if (stray) stray_beats(2);
    issue_start();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < BR; r++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 3)) begin
            abs_valid = 1'b0;
            abs_in = {$urandom, $urandom};
            @(negedge clk);
          end
        end
        drive_beat(make_beat(mode, c), c, r);
        start = mid_start && (c == 1) && (r == 3);
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (stray) stray_beats(2);
    abs_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    check("final_best_sad", best_sad, m_bsad);
    check("final_best_idx", best_idx, m_bidx);
    check("busy_at_done", busy, 0);
    if (lit_sad >= 0) check("lit_best_sad", best_sad, lit_sad);
    if (lit_idx >= 0) check("lit_best_idx", best_idx, lit_idx);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cand_valid"}, cand_sad_valid, 0);
    check({tag, "_cand_sad"}, cand_sad, 0);
    check({tag, "_cand_idx"}, cand_idx, 0);
    check({tag, "_best_sad"}, best_sad, ALL_ONES);
    check({tag, "_best_idx"}, best_idx, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic reset_mid_search();
    issue_start();
    for (int i = 0; i < 11; i++) begin
      drive_beat(make_beat(3, i / BR), i / BR, i % BR);
      @(negedge clk);
    end
    check("pre_reset_best_sad", best_sad, m_bsad);
    rst_n = 1'b0;
    abs_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cq.delete();
    dq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray_beats(3);
    repeat (4) @(negedge clk);
    check_reset_outputs("post_rst");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_search(0, 1'b0, 1'b0, 1'b0, 64, 0);
    // Next start lands in the done cycle.
    do_search(1, 1'b0, 1'b0, 1'b0, 16320, 0);
    do_search(2, 1'b0, 1'b0, 1'b0, 192, 1);
    do_search(2, 1'b1, 1'b1, 1'b1, 192, 1);
    reset_mid_search();
    do_search(3, 1'b1, 1'b1, 1'b0, -1, -1);
    do_search(4, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int k = 0; k < 4; k++) do_search(3 + (k % 2), 1'b1, k[0], 1'b1, -1, -1);
    do_search(4, 1'b1, 1'b1, 1'b0, -1, -1);

    repeat (6) @(negedge clk);
    check("leftover_cand", cq.size(), 0);
    check("leftover_done", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
